// File: rtl/nb_cell_scheduler.sv
// Neighbor-cell sweep sequencer: walks the half or full shell around
// one home cell and issues wrapped neighbor IDs as valid/ready tokens.
package MD_pkg;
  localparam int GLOBAL_CELL_ID_WIDTH = 5;
  localparam int CELL_ID_WIDTH = 2;
endpackage

module nb_cell_scheduler
  import MD_pkg::*;
#(
  parameter int GDIM_X     = 3,
  parameter int GDIM_Y     = 3,
  parameter int GDIM_Z     = 3,
  parameter bit HALF_SHELL = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_home_gcid_x,
  input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_home_gcid_y,
  input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_home_gcid_z,
  input  logic                            i_nb_ready,
  output logic                            o_nb_valid,
  output logic [GLOBAL_CELL_ID_WIDTH-1:0] o_nb_gcid_x,
  output logic [GLOBAL_CELL_ID_WIDTH-1:0] o_nb_gcid_y,
  output logic [GLOBAL_CELL_ID_WIDTH-1:0] o_nb_gcid_z,
  output logic [CELL_ID_WIDTH-1:0]        o_nb_cid_x,
  output logic [CELL_ID_WIDTH-1:0]        o_nb_cid_y,
  output logic [CELL_ID_WIDTH-1:0]        o_nb_cid_z,
  output logic [4:0]                      o_nb_idx,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int GW = GLOBAL_CELL_ID_WIDTH;
  localparam int CW = CELL_ID_WIDTH;

  localparam logic [CW-1:0] C_M = 2'b01;
  localparam logic [CW-1:0] C_Z = 2'b10;
  localparam logic [CW-1:0] C_P = 2'b11;
  localparam logic [CW-1:0] C_START = HALF_SHELL ? C_Z : C_M;

  localparam logic [GW-1:0] XM1 = GW'(GDIM_X - 1);
  localparam logic [GW-1:0] YM1 = GW'(GDIM_Y - 1);
  localparam logic [GW-1:0] ZM1 = GW'(GDIM_Z - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t        state_q;
  logic [GW-1:0] hx_q, hy_q, hz_q;
  logic [CW-1:0] dx_q, dy_q, dz_q;
  logic [4:0]    idx_q;
  logic          done_q;
  logic          err_q;

  function automatic logic [GW-1:0] wrap(
    input logic [GW-1:0] h,
    input logic [CW-1:0] c,
    input logic [GW-1:0] dm1
  );
    case (c)
      C_P:     wrap = (h == dm1) ? '0 : h + 1'b1;
      C_M:     wrap = (h == '0) ? dm1 : h - 1'b1;
      default: wrap = h;
    endcase
  endfunction

  function automatic logic [CW-1:0] nxt(
    input logic [CW-1:0] c
  );
    nxt = (c == C_P) ? C_M : c + 2'd1;
  endfunction

  logic in_range;
  logic hs;
  logic last;

  assign in_range =
    ({1'b0, i_home_gcid_x} < (GW+1)'(GDIM_X)) &&
    ({1'b0, i_home_gcid_y} < (GW+1)'(GDIM_Y)) &&
    ({1'b0, i_home_gcid_z} < (GW+1)'(GDIM_Z));

  assign hs   = (state_q == ISSUE) && i_nb_ready;
  assign last = (dx_q == C_P) && (dy_q == C_P) &&
                (dz_q == C_P);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hx_q    <= '0;
      hy_q    <= '0;
      hz_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      dz_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start && in_range) begin
            hx_q    <= i_home_gcid_x;
            hy_q    <= i_home_gcid_y;
            hz_q    <= i_home_gcid_z;
            dx_q    <= C_START;
            dy_q    <= C_START;
            dz_q    <= C_START;
            idx_q   <= '0;
            state_q <= ISSUE;
          end else if (i_start) begin
            err_q <= 1'b1;
          end
        end
        ISSUE: begin
          // abort wins even when the current token is consumed
          if (i_abort) begin
            state_q <= IDLE;
          end else if (hs && last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (hs) begin
            dz_q  <= nxt(dz_q);
            idx_q <= idx_q + 5'd1;
            if (dz_q == C_P) dy_q <= nxt(dy_q);
            if (dz_q == C_P && dy_q == C_P)
              dx_q <= nxt(dx_q);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_nb_valid = (state_q == ISSUE);
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_err      = err_q;

  assign o_nb_idx    = o_nb_valid ? idx_q : '0;
  assign o_nb_cid_x  = o_nb_valid ? dx_q : '0;
  assign o_nb_cid_y  = o_nb_valid ? dy_q : '0;
  assign o_nb_cid_z  = o_nb_valid ? dz_q : '0;
  assign o_nb_gcid_x = o_nb_valid ? wrap(hx_q, dx_q, XM1) : '0;
  assign o_nb_gcid_y = o_nb_valid ? wrap(hy_q, dy_q, YM1) : '0;
  assign o_nb_gcid_z = o_nb_valid ? wrap(hz_q, dz_q, ZM1) : '0;

endmodule

// File: tb/tb_nb_cell_scheduler.sv
// Scoreboard bench: a half-shell 3x3x3 and a full-shell 4x4x4
// scheduler driven with random homes, backpressure, aborts, resets.
module tb_nb_cell_scheduler;
  import MD_pkg::*;

  localparam int W = GLOBAL_CELL_ID_WIDTH;

  typedef struct packed {
    logic [4:0]   idx;
    logic [W-1:0] gx;
    logic [W-1:0] gy;
    logic [W-1:0] gz;
    logic [1:0]   cx;
    logic [1:0]   cy;
    logic [1:0]   cz;
  } tok_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start [2];
  logic abort [2];
  logic ready [2];
  logic valid [2];
  logic busy  [2];
  logic done  [2];
  logic err   [2];
  logic [W-1:0] hx [2];
  logic [W-1:0] hy [2];
  logic [W-1:0] hz [2];
  logic [W-1:0] gx [2];
  logic [W-1:0] gy [2];
  logic [W-1:0] gz [2];
  logic [1:0] cx [2];
  logic [1:0] cy [2];
  logic [1:0] cz [2];
  logic [4:0] idx [2];

  nb_cell_scheduler #(
    .GDIM_X(3), .GDIM_Y(3), .GDIM_Z(3),
    .HALF_SHELL(1'b1)
  ) u_half (
    .clk(clk), .rst_n(rst_n),
    .i_start(start[0]), .i_abort(abort[0]),
    .i_home_gcid_x(hx[0]),
    .i_home_gcid_y(hy[0]),
    .i_home_gcid_z(hz[0]),
    .i_nb_ready(ready[0]), .o_nb_valid(valid[0]),
    .o_nb_gcid_x(gx[0]), .o_nb_gcid_y(gy[0]),
    .o_nb_gcid_z(gz[0]),
    .o_nb_cid_x(cx[0]), .o_nb_cid_y(cy[0]),
    .o_nb_cid_z(cz[0]),
    .o_nb_idx(idx[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_err(err[0])
  );

  nb_cell_scheduler #(
    .GDIM_X(4), .GDIM_Y(4), .GDIM_Z(4),
    .HALF_SHELL(1'b0)
  ) u_full (
    .clk(clk), .rst_n(rst_n),
    .i_start(start[1]), .i_abort(abort[1]),
    .i_home_gcid_x(hx[1]),
    .i_home_gcid_y(hy[1]),
    .i_home_gcid_z(hz[1]),
    .i_nb_ready(ready[1]), .o_nb_valid(valid[1]),
    .o_nb_gcid_x(gx[1]), .o_nb_gcid_y(gy[1]),
    .o_nb_gcid_z(gz[1]),
    .o_nb_cid_x(cx[1]), .o_nb_cid_y(cy[1]),
    .o_nb_cid_z(cz[1]),
    .o_nb_idx(idx[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_err(err[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tok_t expq [2][$];
  tok_t held [2];
  bit   held_v [2];
  bit   abort_prev [2];
  int   last_hs [2];

  function automatic void chk(string nm,
                              logic [63:0] act,
                              logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, expv, $time);
    end
  endfunction

  function automatic int dim(int k);
    return (k == 0) ? 3 : 4;
  endfunction

  // 1-D neighbor code of a source cell relative to home
  function automatic logic [1:0] code1d(int s, int h, int d);
    if (s == h) return 2'b10;
    if (s == (h + 1) % d) return 2'b11;
    if (s == (h + d - 1) % d) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void build(int k, int x, int y, int z);
    int d = dim(k);
    int n = 0;
    tok_t t;
    for (int a = -1; a <= 1; a++)
      for (int b = -1; b <= 1; b++)
        for (int c = -1; c <= 1; c++) begin
          if (k == 0 && (a * 9 + b * 3 + c) < 0) continue;
          t.idx = 5'(n);
          t.gx = W'((x + a + d) % d);
          t.gy = W'((y + b + d) % d);
          t.gz = W'((z + c + d) % d);
          t.cx = code1d(int'(t.gx), x, d);
          t.cy = code1d(int'(t.gy), y, d);
          t.cz = code1d(int'(t.gz), z, d);
          expq[k].push_back(t);
          n++;
        end
  endfunction

  always @(negedge clk) begin : mon
    tok_t cur;
    tok_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        held_v[k] = 1'b0;
        abort_prev[k] = 1'b0;
      end else begin
        cur = {idx[k], gx[k], gy[k], gz[k],
               cx[k], cy[k], cz[k]};
        if (valid[k]) begin
          if (held_v[k]) chk("stall_hold", cur, held[k]);
          if (ready[k]) begin
            if (expq[k].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL extra_token: got %0h expected none",
                       cur);
            end else begin
              e = expq[k].pop_front();
              chk("token", cur, e);
            end
            last_hs[k] = cyc;
            held_v[k] = 1'b0;
          end else begin
            held[k] = cur;
            held_v[k] = 1'b1;
          end
        end else begin
          if (held_v[k] && !abort_prev[k])
            chk("valid_drop", valid[k], 1);
          held_v[k] = 1'b0;
        end
        if (done[k]) begin
          chk("done_queue_empty", expq[k].size(), 0);
          chk("done_timing", cyc, last_hs[k] + 1);
        end
        abort_prev[k] = abort[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(int k, string nm);
    chk(nm, {valid[k], busy[k], done[k], err[k],
             idx[k], gx[k], gy[k], gz[k],
             cx[k], cy[k], cz[k]}, 0);
  endtask

  task automatic sweep(int k, int x, int y, int z,
                       int rmode, int abort_at,
                       int rst_at, bit inject);
    int waited = 0;
    bit fin = 1'b0;
    build(k, x, y, z);
    start[k] = 1'b1;
    hx[k] = W'(x);
    hy[k] = W'(y);
    hz[k] = W'(z);
    ready[k] = (rmode == 0);
    tick();
    start[k] = 1'b0;
    chk("start_valid", valid[k], 1);
    chk("start_idx", idx[k], 0);
    chk("start_busy", busy[k], 1);
    while (!fin && waited < 300) begin
      case (rmode)
        0: ready[k] = 1'b1;
        1: ready[k] = (waited % 3 == 0);
        default: ready[k] = 1'($urandom_range(0, 1));
      endcase
      if (inject && waited == 4) begin
        start[k] = 1'b1;
        hx[k] = '0;
        hy[k] = '0;
        hz[k] = '0;
      end
      if (abort_at >= 0 && valid[k] &&
          int'(idx[k]) == abort_at) begin
        ready[k] = 1'b1;
        abort[k] = 1'b1;
        tick();
        abort[k] = 1'b0;
        ready[k] = 1'b0;
        chk("abort_valid", valid[k], 0);
        chk("abort_busy", busy[k], 0);
        chk("abort_done", done[k], 0);
        expq[k].delete();
        return;
      end
      if (rst_at >= 0 && valid[k] &&
          int'(idx[k]) == rst_at) begin
        rst_n = 1'b0;
        tick();
        zeros(k, "midreset_zero");
        rst_n = 1'b1;
        ready[k] = 1'b0;
        expq[k].delete();
        return;
      end
      tick();
      start[k] = 1'b0;
      waited++;
      if (done[k]) fin = 1'b1;
    end
    chk("sweep_done_seen", fin, 1);
    chk("done_busy", busy[k], 1);
    chk("done_valid", valid[k], 0);
    ready[k] = 1'b0;
    tick();
    chk("idle_busy", busy[k], 0);
    chk("idle_done", done[k], 0);
    expq[k].delete();
  endtask

  task automatic bad_start(int k, int x, int y, int z);
    start[k] = 1'b1;
    hx[k] = W'(x);
    hy[k] = W'(y);
    hz[k] = W'(z);
    tick();
    start[k] = 1'b0;
    chk("err_pulse", err[k], 1);
    chk("err_valid", valid[k], 0);
    chk("err_busy", busy[k], 0);
    tick();
    chk("err_one_cycle", err[k], 0);
    chk("err_still_idle", valid[k], 0);
  endtask

  initial begin
    int k, d, n, ab, rm;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      ready[i] = 1'b0;
      hx[i] = '0;
      hy[i] = '0;
      hz[i] = '0;
      held_v[i] = 1'b0;
      abort_prev[i] = 1'b0;
      last_hs[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    zeros(0, "reset_zero_half");
    zeros(1, "reset_zero_full");
    rst_n = 1'b1;
    tick();

    sweep(0, 1, 1, 1, 0, -1, -1, 1'b0);
    sweep(1, 0, 0, 3, 0, -1, -1, 1'b0);
    sweep(0, 2, 0, 1, 1, -1, -1, 1'b0);
    sweep(1, 3, 2, 0, 1, -1, -1, 1'b1);
    sweep(0, 1, 1, 1, 0, 5, -1, 1'b0);
    sweep(0, 0, 2, 2, 0, -1, -1, 1'b0);
    bad_start(0, 3, 0, 0);
    bad_start(1, 0, 4, 1);
    sweep(1, 1, 2, 3, 0, -1, 7, 1'b0);
    sweep(1, 1, 2, 3, 2, -1, -1, 1'b0);
    sweep(0, 2, 2, 2, 2, -1, 7, 1'b0);
    sweep(0, 0, 0, 0, 0, -1, -1, 1'b0);

    for (int it = 0; it < 24; it++) begin
      k = int'($urandom_range(0, 1));
      d = dim(k);
      n = (k == 0) ? 14 : 27;
      rm = int'($urandom_range(0, 2));
      ab = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, n - 1)) : -1;
      if ($urandom_range(0, 5) == 0)
        bad_start(k, int'($urandom_range(0, d - 1)),
                  d + int'($urandom_range(0, 3)),
                  int'($urandom_range(0, d - 1)));
      else
        sweep(k, int'($urandom_range(0, d - 1)),
              int'($urandom_range(0, d - 1)),
              int'($urandom_range(0, d - 1)),
              rm, ab, -1, 1'($urandom_range(0, 1)));
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
